// File: rtl/mpr121_pkg.sv
// Shared definitions for the MPR121 I2C target emulator.
//   - state_t      : target FSM states
//   - REG_*        : register addresses with special behaviour
//   - SRST_KEY     : value that triggers a register-file soft reset
//   - reg_default  : power-on / soft-reset value of each register
package mpr121_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] REG_TOUCH_L = 8'h00;
  localparam logic [7:0] REG_TOUCH_H = 8'h01;
  localparam logic [7:0] REG_CDC     = 8'h5C;
  localparam logic [7:0] REG_CDT     = 8'h5D;
  localparam logic [7:0] REG_ECR     = 8'h5E;
  localparam logic [7:0] REG_SRST    = 8'h80;

  localparam logic [7:0] SRST_KEY    = 8'h63;

  localparam logic [7:0] DEF_CDC     = 8'h10;
  localparam logic [7:0] DEF_CDT     = 8'h24;

  function automatic logic [7:0] reg_default(input logic [7:0] addr);
    logic [7:0] val;
    val = 8'h00;
    case (addr)
      REG_CDC: val = DEF_CDC;
      REG_CDT: val = DEF_CDT;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/mpr121_target_i2c_bus_sync.sv
// Bus front end for the MPR121 target.
// Synchronizes SCL/SDA through SYNC_STAGES flops, keeps one delayed copy of
// each, and derives bus events from the synchronized signals.
// Ports:
//   clk, rst_n           : system clock, async active-low reset
//   scl, sda             : raw bus inputs
//   scl_rise, scl_fall   : one-cycle SCL edge strobes
//   start_det, stop_det  : one-cycle START / STOP strobes
//   sda_s                : synchronized SDA
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Idle bus is high, so reset to 1 to avoid false edges on reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SDA may only move while SCL is high for START/STOP; require SCL high
  // in both the current and the delayed sample.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/mpr121_target.sv
// MPR121 capacitive touch controller emulator (I2C target).
// Ports:
//   clk_in, rst_in             : 100 MHz clock, async active-low reset
//   scl_in, sda_in             : I2C bus as seen on the pins
//   sda_oe_out                 : 1 = pull SDA low
//   touch_status_in            : live electrode bits (registers 0x00/0x01)
//   reg_wr_valid_out/addr/data : one-cycle strobe per written data byte
//   busy_out                   : addressed transaction in progress
//   fsm_state_out              : current FSM state (debug)
// Handshake: reg_wr_valid_out is a single-cycle strobe with no back-pressure;
// reg_wr_addr_out/reg_wr_data_out are valid in the cycle it is high.
module mpr121_target
  import mpr121_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h5A,
  parameter int         SYNC_STAGES    = 2,
  parameter int         NUM_ELECTRODES = 12
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      scl_in,
  input  logic                      sda_in,
  output logic                      sda_oe_out,
  input  logic [NUM_ELECTRODES-1:0] touch_status_in,
  output logic                      reg_wr_valid_out,
  output logic [7:0]                reg_wr_addr_out,
  output logic [7:0]                reg_wr_data_out,
  output logic                      busy_out,
  output logic [3:0]                fsm_state_out
);

  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] pointer;
  logic       rw;
  logic       snap_v;
  logic [7:0] snap_hi;
  logic       srst_pend;
  logic [7:0] regs [128];

  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;

  logic       byte_done;
  logic [7:0] rx_byte;
  logic       addr_match;
  logic       load_en;
  logic [7:0] load_ptr;
  logic [7:0] load_byte;
  logic       wr_commit;
  logic [15:0] touch16;
  logic [7:0] touch_hi_live;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .scl       (scl_in),
    .sda       (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign fsm_state_out = state;
  assign touch16       = 16'(touch_status_in);
  assign touch_hi_live = touch16[15:8] & 8'h0F;
  assign byte_done     = scl_rise && (bit_cnt == 3'd7);
  assign rx_byte       = {shreg[6:0], sda_s};
  assign addr_match    = (rx_byte[7:1] == DEV_ADDR);
  assign wr_commit     = !start_det && !stop_det && (state == ST_WDATA) && byte_done;

  // Transmit byte selection. A read burst loads from the pointer at the
  // address ACK, and from pointer+1 after each master ACK.
  always_comb begin
    load_en  = 1'b0;
    load_ptr = pointer;
    if (!start_det && !stop_det && scl_rise) begin
      if (state == ST_ADDR_ACK && rw) begin
        load_en = 1'b1;
      end
      if (state == ST_RDATA_ACK && !sda_s) begin
        load_en  = 1'b1;
        load_ptr = pointer + 8'd1;
      end
    end
    if (load_ptr == REG_TOUCH_L) begin
      load_byte = touch16[7:0];
    end else if (load_ptr == REG_TOUCH_H) begin
      // High touch bits come from the snapshot taken with 0x00 in this burst.
      load_byte = snap_v ? snap_hi : touch_hi_live;
    end else if (!load_ptr[7]) begin
      load_byte = regs[load_ptr[6:0]];
    end else begin
      load_byte = 8'h00;
    end
  end

  // Next-state logic; START/STOP override everything else.
  always_comb begin
    state_nx = state;
    if (start_det) begin
      state_nx = ST_ADDR;
    end else if (stop_det) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:      if (byte_done) state_nx = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (scl_rise)  state_nx = rw ? ST_RDATA : ST_PTR;
        ST_PTR:       if (byte_done) state_nx = ST_PTR_ACK;
        ST_PTR_ACK:   if (scl_rise)  state_nx = ST_WDATA;
        ST_WDATA:     if (byte_done) state_nx = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_rise)  state_nx = ST_WDATA;
        ST_RDATA:     if (byte_done) state_nx = ST_RDATA_ACK;
        ST_RDATA_ACK: if (scl_rise)  state_nx = sda_s ? ST_IGNORE : ST_RDATA;
        default:      state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Bit-level datapath. SDA drive changes only on SCL fall, so it is stable
  // for the whole high phase the master samples in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sda_oe_out       <= 1'b0;
      reg_wr_valid_out <= 1'b0;
      reg_wr_addr_out  <= 8'h00;
      reg_wr_data_out  <= 8'h00;
      busy_out         <= 1'b0;
      bit_cnt          <= 3'd0;
      shreg            <= 8'h00;
      pointer          <= 8'h00;
      rw               <= 1'b0;
      snap_v           <= 1'b0;
      snap_hi          <= 8'h00;
      srst_pend        <= 1'b0;
    end else begin
      reg_wr_valid_out <= 1'b0;
      srst_pend        <= 1'b0;
      if (start_det) begin
        sda_oe_out <= 1'b0;
        bit_cnt    <= 3'd0;
        snap_v     <= 1'b0;
      end else if (stop_det) begin
        sda_oe_out <= 1'b0;
        bit_cnt    <= 3'd0;
        snap_v     <= 1'b0;
        busy_out   <= 1'b0;
      end else begin
        if (scl_fall) begin
          case (state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_out <= 1'b1;
            ST_RDATA:                              sda_oe_out <= ~shreg[7];
            default:                               sda_oe_out <= 1'b0;
          endcase
        end
        if (scl_rise) begin
          case (state)
            ST_ADDR: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                rw       <= sda_s;
                busy_out <= addr_match;
              end
            end
            ST_PTR: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) pointer <= rx_byte;
            end
            ST_WDATA: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                reg_wr_valid_out <= 1'b1;
                reg_wr_addr_out  <= pointer;
                reg_wr_data_out  <= rx_byte;
                pointer          <= pointer + 8'd1;
                srst_pend        <= (pointer == REG_SRST) && (rx_byte == SRST_KEY);
              end
            end
            ST_RDATA: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
            ST_RDATA_ACK: begin
              if (!sda_s) pointer <= pointer + 8'd1;
            end
            default: ;
          endcase
          if (load_en) begin
            shreg <= load_byte;
            if (load_ptr == REG_TOUCH_L) begin
              snap_v  <= 1'b1;
              snap_hi <= touch_hi_live;
            end
          end
        end
      end
    end
  end

  // Register file. Soft reset lands one cycle after the write strobe.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 128; i++) regs[i] <= reg_default(8'(i));
    end else if (srst_pend) begin
      for (int i = 0; i < 128; i++) regs[i] <= reg_default(8'(i));
    end else if (wr_commit && !pointer[7] && (pointer >= 8'h02)) begin
      regs[pointer[6:0]] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_mpr121_target.sv
// Bench for mpr121_target: bit-banged I2C master, transaction-level model of
// the register map and pointer, and a queue of expected write strobes.
module tb_mpr121_target;

  localparam int T = 60;  // quarter SCL period (6 clk_in cycles)
  localparam logic [7:0] ADDR_W   = 8'hB4;
  localparam logic [7:0] ADDR_R   = 8'hB5;
  localparam logic [7:0] ADDR_BAD = 8'hB6;

  logic        clk;
  logic        rst_n;
  logic        scl;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe_out;
  logic [11:0] touch;
  logic        reg_wr_valid_out;
  logic [7:0]  reg_wr_addr_out;
  logic [7:0]  reg_wr_data_out;
  logic        busy_out;
  logic [3:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_regs [256];
  logic [7:0]  m_ptr;
  logic [11:0] m_snap;
  bit          m_snap_v;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  wbytes[$];
  logic [7:0]  rd_q[$];

  bit          tog_en;
  logic [11:0] tog_val;

  typedef struct {
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  assign sda_line = sda_m & ~sda_oe_out;

  mpr121_target dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .scl_in           (scl),
    .sda_in           (sda_line),
    .sda_oe_out       (sda_oe_out),
    .touch_status_in  (touch),
    .reg_wr_valid_out (reg_wr_valid_out),
    .reg_wr_addr_out  (reg_wr_addr_out),
    .reg_wr_data_out  (reg_wr_data_out),
    .busy_out         (busy_out),
    .fsm_state_out    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-strobe monitor
  always @(negedge clk) begin
    if (reg_wr_valid_out) got_q.push_back({reg_wr_addr_out, reg_wr_data_out});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model
  function automatic void model_reset_file();
    for (int i = 0; i < 256; i++) begin
      m_regs[i] = (i == 8'h5C) ? 8'h10 : (i == 8'h5D) ? 8'h24 : 8'h00;
    end
  endfunction

  function automatic void model_wr(input logic [7:0] d);
    exp_q.push_back({m_ptr, d});
    if (m_ptr >= 8'h02 && m_ptr <= 8'h7F) m_regs[m_ptr] = d;
    else if (m_ptr == 8'h80 && d == 8'h63) model_reset_file();
    m_ptr = m_ptr + 8'd1;
  endfunction

  function automatic logic [7:0] model_rd();
    logic [11:0] t;
    if (m_ptr == 8'h00) begin
      m_snap   = touch;
      m_snap_v = 1'b1;
      return touch[7:0];
    end else if (m_ptr == 8'h01) begin
      t = m_snap_v ? m_snap : touch;
      return {4'h0, t[11:8]};
    end else if (m_ptr < 8'h80) begin
      return m_regs[m_ptr];
    end
    return 8'h00;
  endfunction

  // Driver tasks
  task automatic bit_cycle(input logic d, output logic s);
    sda_m = d;
    #(T) scl = 1'b1;
    #(T) s = sda_line;
    #(T) scl = 1'b0;
    #(T);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #(T) scl = 1'b1;
    #(T) sda_m = 1'b0;
    #(T) scl = 1'b0;
    #(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #(T) scl = 1'b1;
    #(T) sda_m = 1'b1;
    #(T);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
      if (i == 4 && tog_en) begin
        touch  = tog_val;
        tog_en = 1'b0;
      end
    end
    bit_cycle(nack, s);
  endtask

  // Scoreboard drain for write strobes
  task automatic check_writes();
    logic [15:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_pulse: got none expected %0h", e);
      end else begin
        g = got_q.pop_front();
        chk("wr_pulse", g, e);
      end
    end
    chk("wr_extra", got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic do_write(input logic [7:0] ptr);
    logic ack;
    i2c_start();
    wr_byte(ADDR_W, ack);
    chk("addr_w_ack", ack, 1);
    chk("busy_set", busy_out, 1);
    wr_byte(ptr, ack);
    chk("ptr_ack", ack, 1);
    m_ptr = ptr;
    foreach (wbytes[i]) begin
      wr_byte(wbytes[i], ack);
      chk("data_ack", ack, 1);
      model_wr(wbytes[i]);
    end
    i2c_stop();
    #(2*T);
    chk("busy_clr", busy_out, 0);
    check_writes();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] got, exp;
    if (set_ptr) begin
      i2c_start();
      wr_byte(ADDR_W, ack);
      chk("addr_w_ack", ack, 1);
      wr_byte(ptr, ack);
      chk("ptr_ack", ack, 1);
      m_ptr = ptr;
    end
    i2c_start();
    wr_byte(ADDR_R, ack);
    chk("addr_r_ack", ack, 1);
    m_snap_v = 1'b0;
    rd_q.delete();
    for (int i = 0; i < n; i++) begin
      exp = model_rd();
      rd_byte(i == n - 1, got);
      chk("rd_data", got, exp);
      rd_q.push_back(got);
      if (i != n - 1) m_ptr = m_ptr + 8'd1;
    end
    chk("rel_after_nack", sda_oe_out, 0);
    i2c_stop();
    #(2*T);
  endtask

  initial begin
    logic ack;
    logic [7:0] rb;
    int op, n;

    rst_n  = 1'b0;
    scl    = 1'b1;
    sda_m  = 1'b1;
    touch  = 12'hA35;
    tog_en = 1'b0;
    tog_val = 12'h000;
    model_reset_file();
    m_ptr = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_oe", sda_oe_out, 0);
    chk("rst_valid", reg_wr_valid_out, 0);
    chk("rst_addr", reg_wr_addr_out, 0);
    chk("rst_data", reg_wr_data_out, 0);
    chk("rst_busy", busy_out, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table: write one byte, read it back
    vecs[0] = '{8'h5E, 8'h8F, 8'h8F};
    vecs[1] = '{8'h02, 8'hA5, 8'hA5};
    vecs[2] = '{8'h7F, 8'h3C, 8'h3C};
    vecs[3] = '{8'h00, 8'h77, 8'h35};
    vecs[4] = '{8'h01, 8'h12, 8'h0A};
    vecs[5] = '{8'h81, 8'h99, 8'h00};
    vecs[6] = '{8'h90, 8'h44, 8'h00};
    for (int v = 0; v < 7; v++) begin
      wbytes.delete();
      wbytes.push_back(vecs[v].wdata);
      do_write(vecs[v].reg_addr);
      do_read(1'b1, vecs[v].reg_addr, 1);
      chk("tbl_rd", rd_q[0], vecs[v].exp_rd);
    end

    // Touch read 0x00/0x01 with repeated START
    touch = 12'hA35;
    do_read(1'b1, 8'h00, 2);
    chk("touch_lo", rd_q[0], 8'h35);
    chk("touch_hi", rd_q[1], 8'h0A);

    // Wrong address: NACK, not busy, no strobes
    i2c_start();
    wr_byte(ADDR_BAD, ack);
    chk("bad_addr_nack", ack, 0);
    chk("bad_addr_busy", busy_out, 0);
    wr_byte(8'h10, ack);
    chk("ignore_nack_ptr", ack, 0);
    wr_byte(8'h22, ack);
    chk("ignore_nack_data", ack, 0);
    i2c_stop();
    #(2*T);
    check_writes();

    // Snapshot coherency: touch changes during byte 0
    touch   = 12'hA35;
    tog_val = 12'h5CA;
    tog_en  = 1'b1;
    do_read(1'b1, 8'h00, 2);
    chk("snap_lo", rd_q[0], 8'h35);
    chk("snap_hi", rd_q[1], 8'h0A);
    do_read(1'b1, 8'h01, 1);
    chk("live_hi", rd_q[0], 8'h05);
    touch = 12'hA35;

    // Soft reset
    wbytes.delete(); wbytes.push_back(8'h55);
    do_write(8'h5C);
    do_read(1'b1, 8'h5C, 1);
    chk("cdc_wr", rd_q[0], 8'h55);
    wbytes.delete(); wbytes.push_back(8'h00);
    do_write(8'h80);
    do_read(1'b1, 8'h5C, 1);
    chk("srst_bad_key", rd_q[0], 8'h55);
    wbytes.delete(); wbytes.push_back(8'h63);
    do_write(8'h80);
    do_read(1'b1, 8'h5C, 1);
    chk("srst_key", rd_q[0], 8'h10);

    // Pointer wrap
    do_read(1'b1, 8'hFF, 2);
    chk("wrap_ff", rd_q[0], 8'h00);
    chk("wrap_00", rd_q[1], 8'h35);

    // Randomized transactions against the model
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      touch = 12'($urandom_range(0, 4095));
      if (op == 0) begin
        wbytes.delete();
        for (int j = 0; j < n; j++) wbytes.push_back(8'($urandom_range(0, 255)));
        do_write(8'($urandom_range(0, 255)));
      end else begin
        do_read(op == 1, 8'($urandom_range(0, 255)), n);
      end
    end
    touch = 12'hA35;

    // Reset mid-byte while the target is pulling SDA low
    wbytes.delete(); wbytes.push_back(8'h00);
    do_write(8'h03);
    i2c_start();
    wr_byte(ADDR_W, ack);
    wr_byte(8'h03, ack);
    i2c_start();
    wr_byte(ADDR_R, ack);
    chk("mid_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1;
      #(T) scl = 1'b1;
      #(T);
      if (i == 2) begin
        chk("rd_bit_low", sda_oe_out, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", sda_oe_out, 0);
        chk("mid_rst_busy", busy_out, 0);
      end else begin
        rb[i] = sda_line;
        #(T) scl = 1'b0;
        #(T);
      end
    end
    sda_m = 1'b1;
    scl   = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_valid", reg_wr_valid_out, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset_file();
    m_ptr = 8'h00;
    do_read(1'b0, 8'h00, 1);
    chk("ptr_after_rst", rd_q[0], 8'h35);
    do_read(1'b1, 8'h5C, 2);
    chk("cdc_after_rst", rd_q[0], 8'h10);
    chk("cdt_after_rst", rd_q[1], 8'h24);
    do_read(1'b1, 8'h03, 1);
    check_writes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
